// File: rtl/pipelined_carry_adder_if.sv
// Operand/result handshake bundle for pipelined_carry_adder.
// The ovf signal exists only when PCA_OVF_FLAG_EN is defined.
interface pipelined_carry_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PCA_OVF_FLAG_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/pipelined_carry_adder.sv
// Pipelined ripple-carry add/subtract, one WIDTH/STAGES slice per clock.
// Define PCA_OVF_FLAG_EN to add the registered signed-overflow output.
module pipelined_carry_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipelined_carry_adder_if.slave bus
);
    localparam int SLICE = WIDTH / STAGES;

    logic adv;
    logic vout;

    assign adv          = !vout || bus.out_ready;
    assign bus.in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        // LO bits are finished on entry, RW operand bits remain.
        localparam int LO = k * SLICE;
        localparam int RW = WIDTH - LO;

        logic [RW-1:0]       a_in;
        logic [RW-1:0]       b_in;
        logic                c_in;
        logic                v_in;
        logic [SLICE-1:0]    s_d;
        logic                c_d;
        logic [LO+SLICE-1:0] r_d;
        logic                v_q;
        logic                c_q;
        logic [LO+SLICE-1:0] r_q;

        if (k == 0) begin : g_first
            assign a_in = bus.a;
            assign b_in = bus.b ^ {WIDTH{bus.sub}};
            assign c_in = bus.sub | bus.cin;
            assign v_in = bus.in_valid;
            assign r_d  = s_d;
        end else begin : g_next
            assign a_in = g_stg[k-1].g_skew.a_q;
            assign b_in = g_stg[k-1].g_skew.b_q;
            assign c_in = g_stg[k-1].c_q;
            assign v_in = g_stg[k-1].v_q;
            assign r_d  = {s_d, g_stg[k-1].r_q};
        end

        assign {c_d, s_d} = {1'b0, a_in[SLICE-1:0]}
                          + {1'b0, b_in[SLICE-1:0]}
                          + {{SLICE{1'b0}}, c_in};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                r_q <= '0;
            end else if (adv) begin
                v_q <= v_in;
                c_q <= c_d;
                r_q <= r_d;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [RW-SLICE-1:0] a_q;
            logic [RW-SLICE-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_in[RW-1:SLICE];
                    b_q <= b_in[RW-1:SLICE];
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
            assign vout          = v_q;
            assign bus.out_valid = v_q;
            assign bus.sum       = r_q;
            assign bus.cout      = c_q;
`ifdef PCA_OVF_FLAG_EN
            logic ovf_d;
            logic ovf_q;

            // a^b^s at the MSB recovers the carry into it.
            assign ovf_d = a_in[SLICE-1] ^ b_in[SLICE-1]
                         ^ s_d[SLICE-1] ^ c_d;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= ovf_d;
                end
            end

            assign bus.ovf = ovf_q;
`endif
        end
    end

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Bench for pipelined_carry_adder: directed cases plus random
// traffic checked every cycle against an arithmetic queue model.
module tb_pipelined_carry_adder #(
    parameter int STAGES = 4
);
    localparam int WIDTH = 16;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        longint      stamp;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b1;
    int     n_chk = 0;
    int     n_pass = 0;
    longint advn = 0;
    exp_t   q[$];

    pipelined_carry_adder_if #(.WIDTH(WIDTH)) bus();

    pipelined_carry_adder #(
        .WIDTH (WIDTH),
        .STAGES(STAGES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] ref_add(
        logic [15:0] a_, logic [15:0] b_, logic c_, logic s_);
        logic [15:0] bp;
        logic [16:0] f;
        logic        o;
        bp = s_ ? ~b_ : b_;
        f  = {1'b0, a_} + {1'b0, bp} + {16'b0, (s_ | c_)};
        o  = (a_[15] == bp[15]) && (f[15] != a_[15]);
        return {o, f};
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h @%0t",
                      nm, got, exp, $time);
    endtask

    // Scoreboard: a beat reaches the output after STAGES advancing edges.
    always @(negedge clk) begin
        logic       exp_v;
        logic       a_ok;
        logic [17:0] r;
        exp_t       e;
        if (!rst_n) begin
            q.delete();
            chk("rst_out_valid", {31'b0, bus.out_valid}, 0);
            chk("rst_sum", {16'b0, bus.sum}, 0);
            chk("rst_cout", {31'b0, bus.cout}, 0);
`ifdef PCA_OVF_FLAG_EN
            chk("rst_ovf", {31'b0, bus.ovf}, 0);
`endif
        end else begin
            exp_v = (q.size() > 0) && (advn - q[0].stamp == STAGES);
            chk("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_v});
            a_ok = !exp_v || bus.out_ready;
            chk("in_ready", {31'b0, bus.in_ready}, {31'b0, a_ok});
            if (exp_v) begin
                chk("sum", {16'b0, bus.sum}, {16'b0, q[0].s});
                chk("cout", {31'b0, bus.cout}, {31'b0, q[0].c});
`ifdef PCA_OVF_FLAG_EN
                chk("ovf", {31'b0, bus.ovf}, {31'b0, q[0].o});
`endif
                if (bus.out_ready) void'(q.pop_front());
            end
            if (bus.in_valid && a_ok) begin
                r = ref_add(bus.a, bus.b, bus.cin, bus.sub);
                e.s = r[15:0];
                e.c = r[16];
                e.o = r[17];
                e.stamp = advn;
                q.push_back(e);
            end
            if (a_ok) advn++;
        end
    end

    task automatic rand_ops();
        logic [15:0] v;
        for (int i = 0; i < 2; i++) begin
            case ($urandom_range(0, 5))
                0: v = 16'h0000;
                1: v = 16'hFFFF;
                2: v = 16'h8000;
                3: v = 16'h7FFF;
                default: v = 16'($urandom);
            endcase
            if (i == 0) bus.a = v;
            else bus.b = v;
        end
        bus.cin = 1'($urandom);
        bus.sub = 1'($urandom);
    endtask

    task automatic beat(string nm, logic [15:0] a_, logic [15:0] b_,
                        logic c_, logic s_, logic [15:0] es,
                        logic ec, logic eo);
        int lat;
        @(posedge clk); #1;
        bus.a = a_;
        bus.b = b_;
        bus.cin = c_;
        bus.sub = s_;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_lat"}, lat, STAGES);
        chk({nm, "_sum"}, {16'b0, bus.sum}, {16'b0, es});
        chk({nm, "_cout"}, {31'b0, bus.cout}, {31'b0, ec});
`ifdef PCA_OVF_FLAG_EN
        chk({nm, "_ovf"}, {31'b0, bus.ovf}, {31'b0, eo});
`else
        if (eo) begin end
`endif
    endtask

    task automatic drain();
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (STAGES + 4) @(posedge clk);
    endtask

    task automatic stream8();
        int  sent = 0;
        int  cyc = 0;
        int  st = -1;
        bit  xf;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        rand_ops();
        bus.in_valid = 1'b1;
        while (sent < 8 && cyc < 200) begin
            @(negedge clk);
            if (st < 0 && bus.out_valid) st = cyc + 1;
            if (!bus.out_ready)
                chk("stall_in_ready", {31'b0, bus.in_ready}, 0);
            xf = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            cyc++;
            if (xf) begin
                sent++;
                if (sent < 8) rand_ops();
                else bus.in_valid = 1'b0;
            end
            bus.out_ready = !(st >= 0 && cyc >= st && cyc < st + 3);
        end
        chk("stream_sent", sent, 8);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] r;
        int          seen;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        bus.sub = 1'b0;
        bus.out_ready = 1'b1;

        r = ref_add(16'h1234, 16'h0FED, 1'b1, 1'b0);
        chk("model_add", {14'b0, r}, {14'b0, 18'h02222});
        r = ref_add(16'h8000, 16'h0001, 1'b0, 1'b1);
        chk("model_sub", {14'b0, r}, {14'b0, 18'h37FFF});

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", {31'b0, bus.in_ready}, 1);
        chk("reset_valid", {31'b0, bus.out_valid}, 0);

        beat("t1", 16'h1234, 16'h0FED, 1'b1, 1'b0, 16'h2222, 1'b0, 1'b0);
        beat("t2", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        beat("t3", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        beat("t3c", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        drain();

        stream8();
        drain();

        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, bus.out_valid}, 0);
        chk("async_rst_sum", {16'b0, bus.sum}, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        seen = 0;
        repeat (2 * STAGES + 4) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("no_stale_beat", seen, 0);

        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            rand_ops();
            bus.in_valid = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 7);
        end
        drain();
        chk("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
